// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor.
// Ports: clk, rst (async high), in_valid/in_ready + A,B; out_valid/out_ready + Q,R,div_by_zero,overflow.
// Macro SEQ_DIVIDER_RADIX4_EN: retire two quotient bits per cycle instead of one.
module seq_divider #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           div_by_zero,
  output logic           overflow
);

`ifdef SEQ_DIVIDER_RADIX4_EN
  localparam int STEPS = N / 2;
`else
  localparam int STEPS = N;
`endif
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [N:0]    rem, rem_a, rem_n;
  logic [N-1:0]  qsr, qsr_a, qsr_n;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic          last;
  logic          b_zero;
  logic          too_big;

  // One restoring step. The partial remainder stays below the divisor,
  // so s < 2*d and the top bit of s - d is a valid sign bit.
  function automatic logic [2*N:0] step(
    input logic [N:0]   rm,
    input logic [N-1:0] qs,
    input logic [N-1:0] d
  );
    logic [N:0] s;
    logic [N:0] t;
    s = {rm[N-1:0], qs[N-1]};
    t = s - {1'b0, d};
    if (!t[N])
      step = {t, qs[N-2:0], 1'b1};
    else
      step = {s, qs[N-2:0], 1'b0};
  endfunction

  always_comb begin
    {rem_a, qsr_a} = step(rem, qsr, dvs);
`ifdef SEQ_DIVIDER_RADIX4_EN
    {rem_n, qsr_n} = step(rem_a, qsr_a, dvs);
`else
    rem_n = rem_a;
    qsr_n = qsr_a;
`endif
  end

  assign last      = (cnt == CW'(STEPS - 1));
  assign b_zero    = (B == '0);
  assign too_big   = (A[2*N-1:N] >= B);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid)
          state_nxt = (b_zero || too_big) ? DONE : CALC;
      end
      CALC: begin
        if (last)
          state_nxt = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      qsr         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (b_zero) begin
              Q           <= '1;
              R           <= A[N-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (too_big) begin
              Q           <= '1;
              R           <= A[N-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              rem         <= {1'b0, A[2*N-1:N]};
              qsr         <= A[N-1:0];
              dvs         <= B;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          qsr <= qsr_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            Q <= qsr_n;
            R <= rem_n[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, backpressure,
// mid-operation reset and randomized ops against an arithmetic model.
module tb_seq_divider;
  localparam int N = 24;
`ifdef SEQ_DIVIDER_RADIX4_EN
  localparam int LAT = N / 2;
`else
  localparam int LAT = N;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] A;
  logic [N-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   Q;
  logic [N-1:0]   R;
  logic           dbz;
  logic           ovf;

  int errors = 0;
  int checks = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q(Q),
    .R(R),
    .div_by_zero(dbz),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           dbz;
    logic           ovf;
    bit             err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division plus the two error rules.
  function automatic vec_t model(input logic [2*N-1:0] a,
                                 input logic [N-1:0] b);
    vec_t v;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] qq;
    logic [63:0] rr;
    v.a = a;
    v.b = b;
    v.dbz = 1'b0;
    v.ovf = 1'b0;
    v.err = 1'b1;
    v.q = '1;
    v.r = a[N-1:0];
    if (b == 0) begin
      v.dbz = 1'b1;
    end else if (a[2*N-1:N] >= b) begin
      v.ovf = 1'b1;
    end else begin
      aa = 64'(a);
      bb = 64'(b);
      qq = aa / bb;
      rr = aa % bb;
      v.q = qq[N-1:0];
      v.r = rr[N-1:0];
      v.err = 1'b0;
    end
    return v;
  endfunction

  // lat = clock edges after the acceptance edge until out_valid is seen.
  task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                        input int hold, output vec_t res, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) chk("timeout", 64'd0, 64'd1);
    res.a = a;
    res.b = b;
    res.q = Q;
    res.r = R;
    res.dbz = dbz;
    res.ovf = ovf;
    res.err = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_stable", {out_valid, dbz, ovf, Q, R},
          {1'b1, res.dbz, res.ovf, res.q, res.r});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t tbl[6];
  vec_t got;
  vec_t exp_v;
  int   lat;
  int   seen;
  logic [N-1:0] rb;
  logic [N-1:0] ahi;
  logic [63:0]  lhs;
  int   sel;

  initial begin
    tbl[0] = '{a:48'd100, b:24'd7, q:24'd14, r:24'd2,
               dbz:0, ovf:0, err:0};
    tbl[1] = '{a:48'h000000123456, b:24'd0, q:24'hFFFFFF,
               r:24'h123456, dbz:1, ovf:0, err:1};
    tbl[2] = '{a:48'h000001000000, b:24'd1, q:24'hFFFFFF,
               r:24'h000000, dbz:0, ovf:1, err:1};
    tbl[3] = '{a:48'hFFFFFE000001, b:24'hFFFFFF, q:24'hFFFFFF,
               r:24'd0, dbz:0, ovf:0, err:0};
    tbl[4] = '{a:48'd0, b:24'd5, q:24'd0, r:24'd0,
               dbz:0, ovf:0, err:0};
    tbl[5] = '{a:48'd1000, b:24'd3, q:24'd333, r:24'd1,
               dbz:0, ovf:0, err:0};

    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    A = 48'd100;
    B = 24'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, dbz, ovf, Q, R}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", {in_ready, out_valid}, {1'b1, 1'b0});

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, 0, got, lat);
      chk($sformatf("vec%0d_q", i), 64'(got.q), 64'(tbl[i].q));
      chk($sformatf("vec%0d_r", i), 64'(got.r), 64'(tbl[i].r));
      chk($sformatf("vec%0d_flags", i), {got.dbz, got.ovf},
          {tbl[i].dbz, tbl[i].ovf});
      chk($sformatf("vec%0d_lat", i), 64'(lat),
          tbl[i].err ? 64'd0 : 64'(LAT));
      chk($sformatf("vec%0d_ready", i), {in_ready, out_valid},
          {1'b1, 1'b0});
    end

    // Backpressure with live, changing operands on the input port.
    A = 48'd100;
    B = 24'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 200) begin
      @(posedge clk); #1; seen++;
    end
    chk("bp_lat", 64'(seen), 64'(LAT));
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      A = {$urandom, $urandom};
      B = N'($urandom);
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, dbz, ovf, Q, R},
          {1'b1, 1'b0, 1'b0, 1'b0, 24'd14, 24'd2});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {in_ready, out_valid}, {1'b1, 1'b0});
    @(posedge clk); #1;
    chk("bp_no_accept", {in_ready, out_valid}, {1'b1, 1'b0});

    // Reset during the 10th CALC cycle.
    A = 48'd1000;
    B = 24'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", {out_valid, dbz, ovf, Q, R}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_no_result", 64'(seen), 64'd0);
    run_op(48'd1000, 24'd3, 0, got, lat);
    chk("rst_next_op", {got.q, got.r}, {24'd333, 24'd1});

    // Randomized ops, mostly on the normal path.
    for (int n = 0; n < 2000; n++) begin
      sel = int'($urandom_range(15, 0));
      if (sel == 0)
        rb = '0;
      else
        rb = N'($urandom_range(32'hFFFFFF, 1));
      if (sel == 1)
        ahi = N'($urandom_range(32'hFFFFFF, 32'(rb)));
      else if (rb == 0)
        ahi = N'($urandom);
      else
        ahi = N'($urandom_range(32'(rb) - 1, 0));
      exp_v = model({ahi, N'($urandom)}, rb);
      run_op(exp_v.a, rb, int'($urandom_range(2, 0)), got, lat);
      chk("rnd_qr", {got.q, got.r}, {exp_v.q, exp_v.r});
      chk("rnd_flags", {got.dbz, got.ovf}, {exp_v.dbz, exp_v.ovf});
      chk("rnd_lat", 64'(lat), exp_v.err ? 64'd0 : 64'(LAT));
      if (!exp_v.err) begin
        lhs = 64'(got.q) * 64'(rb) + 64'(got.r);
        chk("rnd_invariant", {lhs == 64'(exp_v.a), got.r < rb},
            2'b11);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
